// File: rtl/mem_stage_pkg.sv
// Shared pipeline types for the memory stage: control word, stage records,
// data-bus request/response and the memory-stage FSM state.
package pipes;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  localparam logic [1:0] MEMRW_NONE  = 2'b00;
  localparam logic [1:0] MEMRW_READ  = 2'b01;
  localparam logic [1:0] MEMRW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HELD = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic       regwrite;
    logic [4:0] dst;
    logic [1:0] MemRW;
    msize_t     msize;
    logic       mem_unsigned;
  } control_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    control_t    ctl;
    logic [63:0] alu;
    logic [63:0] rs2;
  } execute_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    control_t    ctl;
    logic [63:0] result;
    logic        addr31;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  // 2'b11 is deliberately not a memory op.
  function automatic logic is_mem_op(input logic [1:0] rw);
    return (rw == MEMRW_READ) || (rw == MEMRW_WRITE);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for the data bus: store strobe/shift and load
// extraction with sign or zero extension. Purely combinational.
module mem_align
  import pipes::*;
(
  input  logic [2:0]  off,
  input  msize_t      size,
  input  logic        mem_unsigned,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata_raw,
  output logic [7:0]  strobe,
  output logic [63:0] wdata_shifted,
  output logic [63:0] rdata_ext
);

  logic [7:0]  mask;
  logic [63:0] rshift;

  // Store side: lanes past 7 simply fall off the 8-bit strobe and the shift.
  always_comb begin
    mask = 8'h01;
    unique case (size)
      MSIZE1: mask = 8'h01;
      MSIZE2: mask = 8'h03;
      MSIZE4: mask = 8'h0f;
      MSIZE8: mask = 8'hff;
    endcase
    strobe        = mask << off;
    wdata_shifted = wdata << {off, 3'b000};
  end

  // Load side: bring the addressed byte to lane 0, then extend.
  always_comb begin
    rshift    = rdata_raw >> {off, 3'b000};
    rdata_ext = rshift;
    unique case (size)
      MSIZE1: rdata_ext = mem_unsigned ? {56'b0, rshift[7:0]}
                                       : {{56{rshift[7]}}, rshift[7:0]};
      MSIZE2: rdata_ext = mem_unsigned ? {48'b0, rshift[15:0]}
                                       : {{48{rshift[15]}}, rshift[15:0]};
      MSIZE4: rdata_ext = mem_unsigned ? {32'b0, rshift[31:0]}
                                       : {{32{rshift[31]}}, rshift[31:0]};
      MSIZE8: rdata_ext = rshift;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV64I memory stage: E/M register, data-bus request handshake, load
// alignment and the record handed to writeback.
module mem_stage
  import pipes::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  execute_data_t dataE,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM,
  output logic          mem_busy
);

  execute_data_t cur;
  mem_state_t    state;
  logic [63:0]   rdata_q;
  logic          load_cur;
  logic          cur_is_mem;
  logic          cur_is_read;
  logic          cur_is_write;
  logic [7:0]    strobe_w;
  logic [63:0]   wdata_w;
  logic [63:0]   load_src;
  logic [63:0]   load_ext;
  logic          unused_addr_ok;

  assign unused_addr_ok = dresp.addr_ok;

  assign cur_is_read  = cur.ctl.MemRW == MEMRW_READ;
  assign cur_is_write = cur.ctl.MemRW == MEMRW_WRITE;
  assign cur_is_mem   = is_mem_op(cur.ctl.MemRW);
  assign mem_busy     = (state == REQ) && !dresp.data_ok;
  assign load_cur     = !stall && !mem_busy;
  assign load_src     = (state == HELD) ? rdata_q : dresp.data;

  mem_align u_align (
    .off          (cur.alu[2:0]),
    .size         (cur.ctl.msize),
    .mem_unsigned (cur.ctl.mem_unsigned),
    .wdata        (cur.rs2),
    .rdata_raw    (load_src),
    .strobe       (strobe_w),
    .wdata_shifted(wdata_w),
    .rdata_ext    (load_ext)
  );

  // E/M register and access FSM; a REQ that completes without stall
  // falls straight into the load rule, giving back-to-back requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= '0;
      state   <= IDLE;
      rdata_q <= '0;
    end else if (load_cur) begin
      cur   <= dataE;
      state <= (dataE.valid && is_mem_op(dataE.ctl.MemRW)) ? REQ : IDLE;
    end else if (state == REQ && dresp.data_ok) begin
      state   <= HELD;
      rdata_q <= dresp.data;
    end
  end

  // Bus request and writeback record.
  always_comb begin
    dreq.valid    = state == REQ;
    dreq.addr     = cur.alu;
    dreq.size     = cur.ctl.msize;
    dreq.strobe   = cur_is_write ? strobe_w : '0;
    dreq.data     = wdata_w;
    dataM.valid   = cur.valid && !mem_busy;
    dataM.pc      = cur.pc;
    dataM.ctl     = cur.ctl;
    dataM.result  = cur_is_read ? load_ext : cur.alu;
    dataM.addr31  = cur_is_mem ? cur.alu[31] : 1'b0;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writeback records
// and bus requests; a monitor pops and compares them as the DUT presents them.
module tb_mem_stage;
  import pipes::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  execute_data_t dataE;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  memory_data_t  dataM;
  logic          mem_busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] result;
    logic        addr31;
  } exp_m_t;

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } exp_r_t;

  exp_m_t exp_q[$];
  exp_r_t req_q[$];

  mem_stage dut (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .dataE   (dataE),
    .dreq    (dreq),
    .dresp   (dresp),
    .dataM   (dataM),
    .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%016h expected=0x%016h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic execute_data_t mk(input logic [63:0] pc, input logic [1:0] rw,
                                       input msize_t sz, input logic uns,
                                       input logic [63:0] alu, input logic [63:0] rs2);
    execute_data_t e;
    e = '0;
    e.valid            = 1'b1;
    e.pc               = pc;
    e.ctl.regwrite     = rw != MEMRW_WRITE;
    e.ctl.dst          = 5'd5;
    e.ctl.MemRW        = rw;
    e.ctl.msize        = sz;
    e.ctl.mem_unsigned = uns;
    e.alu              = alu;
    e.rs2              = rs2;
    return e;
  endfunction

  task automatic push_m(input logic [63:0] pc, input logic [63:0] res, input logic a31);
    exp_m_t m;
    m.pc = pc; m.result = res; m.addr31 = a31;
    exp_q.push_back(m);
  endtask

  task automatic push_r(input logic [63:0] addr, input logic [1:0] sz,
                        input logic [7:0] strb, input logic [63:0] data);
    exp_r_t r;
    r.addr = addr; r.size = sz; r.strobe = strb; r.data = data;
    req_q.push_back(r);
  endtask

  // Single memory op with a response after `delay` wait cycles, no stall.
  task automatic mem_op(input execute_data_t op, input logic [63:0] rdata,
                        input int unsigned delay, input string tag);
    dataE = op;
    tick();
    dataE = '0;
    for (int unsigned i = 0; i < delay; i++) begin
      dresp.data_ok = 1'b0;
      @(negedge clk);
      chk({tag, "_busy_wait"}, {63'b0, mem_busy}, 64'd1);
      chk({tag, "_dreq_valid_wait"}, {63'b0, dreq.valid}, 64'd1);
      chk({tag, "_dataM_valid_wait"}, {63'b0, dataM.valid}, 64'd0);
      tick();
    end
    dresp.data_ok = 1'b1;
    dresp.data    = rdata;
    @(negedge clk);
    chk({tag, "_busy_done"}, {63'b0, mem_busy}, 64'd0);
    chk({tag, "_dataM_valid_done"}, {63'b0, dataM.valid}, 64'd1);
    tick();
    dresp.data_ok = 1'b0;
    dresp.data    = 64'hDEAD_DEAD_DEAD_DEAD;
  endtask

  // Monitor: writeback consumes dataM on unstalled edges; requests complete on data_ok.
  initial begin
    exp_m_t m;
    exp_r_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (dataM.valid && !stall) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_dataM pc=0x%016h result=0x%016h", dataM.pc, dataM.result);
          end else begin
            m = exp_q.pop_front();
            chk("dataM_pc", dataM.pc, m.pc);
            chk("dataM_result", dataM.result, m.result);
            chk("dataM_addr31", {63'b0, dataM.addr31}, {63'b0, m.addr31});
          end
        end
        if (dreq.valid && dresp.data_ok) begin
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_dreq addr=0x%016h", dreq.addr);
          end else begin
            r = req_q.pop_front();
            chk("dreq_addr", dreq.addr, r.addr);
            chk("dreq_size", {62'b0, dreq.size}, {62'b0, r.size});
            chk("dreq_strobe", {56'b0, dreq.strobe}, {56'b0, r.strobe});
            chk("dreq_data", dreq.data, r.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    dataE = '0;
    dresp = '0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_dreq_valid", {63'b0, dreq.valid}, 64'd0);
    chk("reset_mem_busy", {63'b0, mem_busy}, 64'd0);
    chk("reset_dataM_valid", {63'b0, dataM.valid}, 64'd0);

    // Test 1: ADD, zero added latency, no bus activity.
    push_m(64'h100, 64'h1234, 1'b0);
    dataE = mk(64'h100, MEMRW_NONE, MSIZE8, 1'b0, 64'h1234, 64'h0);
    tick();
    dataE = '0;
    @(negedge clk);
    chk("add_dataM_valid", {63'b0, dataM.valid}, 64'd1);
    chk("add_dreq_valid", {63'b0, dreq.valid}, 64'd0);
    tick();

    // Test 2: LB / LBU at 0x80000003, two wait cycles.
    push_m(64'h104, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
    push_r(64'h8000_0003, 2'd0, 8'h00, 64'h0);
    mem_op(mk(64'h104, MEMRW_READ, MSIZE1, 1'b0, 64'h8000_0003, 64'h0),
           64'h0000_0000_8000_0000, 2, "lb");
    push_m(64'h108, 64'h80, 1'b1);
    push_r(64'h8000_0003, 2'd0, 8'h00, 64'h0);
    mem_op(mk(64'h108, MEMRW_READ, MSIZE1, 1'b1, 64'h8000_0003, 64'h0),
           64'h0000_0000_8000_0000, 2, "lbu");

    // Test 3: SH at lane 6.
    push_m(64'h10C, 64'h1006, 1'b0);
    push_r(64'h1006, 2'd1, 8'hC0, 64'hBEEF_0000_0000_0000);
    mem_op(mk(64'h10C, MEMRW_WRITE, MSIZE2, 1'b0, 64'h1006, 64'hBEEF),
           64'h0, 1, "sh");

    // Test 4: LD completes under stall, data held for three more cycles.
    push_m(64'h110, 64'h1122_3344_5566_7788, 1'b0);
    push_r(64'h2000, 2'd3, 8'h00, 64'h0);
    push_m(64'h114, 64'h55, 1'b0);
    dataE = mk(64'h110, MEMRW_READ, MSIZE8, 1'b0, 64'h2000, 64'h0);
    tick();
    dataE = mk(64'h114, MEMRW_NONE, MSIZE8, 1'b0, 64'h55, 64'h0);
    stall = 1'b1;
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h1122_3344_5566_7788;
    @(negedge clk);
    chk("ld_stall_dataM_valid", {63'b0, dataM.valid}, 64'd1);
    chk("ld_stall_busy", {63'b0, mem_busy}, 64'd0);
    tick();
    dresp.data_ok = 1'b0;
    dresp.data    = 64'hDEAD_DEAD_DEAD_DEAD;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ld_held_dreq_valid", {63'b0, dreq.valid}, 64'd0);
      chk("ld_held_dataM_valid", {63'b0, dataM.valid}, 64'd1);
      chk("ld_held_result", dataM.result, 64'h1122_3344_5566_7788);
      if (i < 2) tick();
    end
    @(posedge clk);
    #1;
    stall = 1'b0;
    tick();
    dataE = '0;
    @(negedge clk);
    chk("ld_next_captured_pc", dataM.pc, 64'h114);
    tick();

    // Test 5: SD then LW, both answered in the same cycle, no bubble.
    push_m(64'h120, 64'h3008, 1'b0);
    push_r(64'h3008, 2'd3, 8'hFF, 64'hCAFE_BABE_1234_5678);
    push_m(64'h124, 64'hFFFF_FFFF_8765_4321, 1'b0);
    push_r(64'h3004, 2'd2, 8'h00, 64'h0);
    dataE = mk(64'h120, MEMRW_WRITE, MSIZE8, 1'b0, 64'h3008, 64'hCAFE_BABE_1234_5678);
    tick();
    dataE = mk(64'h124, MEMRW_READ, MSIZE4, 1'b0, 64'h3004, 64'h0);
    dresp.data_ok = 1'b1;
    @(negedge clk);
    chk("sd_busy", {63'b0, mem_busy}, 64'd0);
    chk("sd_dreq_valid", {63'b0, dreq.valid}, 64'd1);
    tick();
    dataE = '0;
    dresp.data = 64'h8765_4321_0000_0000;
    @(negedge clk);
    chk("lw_busy", {63'b0, mem_busy}, 64'd0);
    chk("lw_dreq_valid_no_bubble", {63'b0, dreq.valid}, 64'd1);
    tick();
    dresp.data_ok = 1'b0;
    @(negedge clk);
    chk("b2b_dreq_idle", {63'b0, dreq.valid}, 64'd0);
    tick();

    // Test 6: reset while a request is pending.
    dataE = mk(64'h130, MEMRW_READ, MSIZE4, 1'b0, 64'h4000, 64'h0);
    tick();
    dataE = '0;
    @(negedge clk);
    chk("rst_req_dreq_valid", {63'b0, dreq.valid}, 64'd1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_mid_dreq_valid", {63'b0, dreq.valid}, 64'd0);
    chk("rst_mid_dataM_valid", {63'b0, dataM.valid}, 64'd0);
    chk("rst_mid_busy", {63'b0, mem_busy}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_dreq_valid", {63'b0, dreq.valid}, 64'd0);

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("req_q_drained", 64'(req_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the RV64I five-stage pipeline. It sits between execute and writeback. It holds the E/M pipeline register, drives the data bus for loads and stores, and aligns, sign-extends or zero-extends load data. It produces the `memory_data_t` record that writeback consumes. It also tells the hazard logic whether it is blocked on the bus.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  global pipeline stall from the hazard unit. While high, the E/M register holds.
- `dataE`  in  `execute_data_t`  execute-stage result. Captured when `stall` and `mem_busy` are both low.
- `dreq`  out  `dbus_req_t`  data-bus request: `valid`, `addr`, `size`, `strobe`, `data`.
- `dresp`  in  `dbus_resp_t`  data-bus response: `addr_ok`, `data_ok`, `data`.
- `dataM`  out  `memory_data_t`  record for writeback.
- `mem_busy`  out  1  high while a bus access for the held instruction is outstanding.

## Operation
- `ctl.MemRW` encoding: 2'b00 none, 2'b01 read, 2'b10 write. 2'b11 is treated as none.
- Register `cur`: loads `dataE` on a rising edge when `!stall && !mem_busy`. Otherwise it holds.
- FSM states, per held instruction:
  - `IDLE`: no access pending.
  - `REQ`: access issued, waiting for `data_ok`.
  - `HELD`: access finished, pipeline still stalled.
- FSM transitions:
  - Any state, on a `cur` load: go to `REQ` if the new `cur.valid` is set and MemRW is read or write; otherwise go to `IDLE`.
  - `REQ` with `data_ok` and `stall`: go to `HELD` and latch `dresp.data` into `rdata_q`.
  - `REQ` with `data_ok` and `!stall`: the `cur` load happens in the same edge, so the next state follows the load rule.
  - `HELD` with `!stall`: load rule.
- Outputs:
  - `mem_busy` = (state==`REQ`) && !`dresp.data_ok`.
  - `dreq.valid` = (state==`REQ`). It stays high until `data_ok`, regardless of `addr_ok`. It is never re-raised for the same instruction.
  - `dreq.addr` = `cur.alu`.
  - `dreq.size` = `cur.ctl.msize`, where MSIZE1/2/4/8 = 0/1/2/3.
- Store alignment, with off = `alu[2:0]`:
  - `dreq.data` = `rs2 << 8*off`.
  - `dreq.strobe` = (8'h01/8'h03/8'h0f/8'hff per size) << off, truncated to 8 bits.
  - Reads drive `strobe` = 0.
- Load data source:
  - `dresp.data` in `REQ`; `rdata_q` in `HELD`.
  - Shift right by 8*off, take the low 1/2/4/8 bytes.
  - Zero-extend if `ctl.mem_unsigned`, else sign-extend to 64 bits.
- `dataM` fields:
  - `ctl` and `pc` copied from `cur`.
  - `result`: extended load data for reads, `cur.alu` otherwise.
  - `addr31`: `cur.alu[31]` for memory ops, 0 otherwise.
  - `valid` = `cur.valid && !mem_busy`.
- Misaligned accesses that cross an 8-byte line are unsupported. Bytes shifted past lane 7 are dropped. No exception is raised.

## Timing
- Reset values: `cur` = 0 (so `dataM.valid` = 0), state `IDLE`, `dreq.valid` = 0, `mem_busy` = 0, `rdata_q` = 0.
- Non-memory instruction: `dataM` is valid the cycle after capture, with zero added latency.
- Memory instruction:
  - `dreq.valid` rises the cycle after capture.
  - `dataM.valid` goes high in the same cycle `data_ok` is seen, combinationally from `dresp`.
- Same-cycle `data_ok` response: `mem_busy` never rises.
- Back-to-back memory ops: a new request can be issued the cycle after the previous `data_ok`, with no bubble.
- `stall` during `REQ`: the request is still held to completion. Data is retained in `HELD`, and `dataM` stays valid and stable.
- `reset` mid-`REQ`: `dreq.valid` drops next edge and the pending access is abandoned. The bus is reset together with the core.

## Structure
- Add to package `pipes`:
  - `mem_state_t` enum {`IDLE`, `REQ`, `HELD`}.
  - Constants `MEMRW_NONE`, `MEMRW_READ`, `MEMRW_WRITE`.
- Sub-module `mem_align`: combinational; computes strobe, store shift, load extraction and extension. It is reused by any future MMIO path.

## Test plan
- Test 1: ADD, alu=0x1234, no stall. Expect: `dataM.valid` the next cycle, `result`=0x1234, `dreq.valid` never high.
- Test 2: LB at alu=0x80000003, memory dword 0x0000_0000_8000_0000, `data_ok` 2 cycles late. Expect: `mem_busy` high 2 cycles, `result`=0xFFFF_FFFF_FFFF_FF80, `addr31`=1. Repeat as LBU: `result`=0x80.
- Test 3: SH rs2=0xBEEF at alu=0x1006. Expect: `strobe`=8'hC0, `data`=0xBEEF_0000_0000_0000, `size`=MSIZE2.
- Test 4: LD with `data_ok` while `stall`=1 for 3 further cycles. Expect: one request only, state `HELD`, `result` stable, new `dataE` captured on the first `!stall` edge.
- Test 5: SD followed immediately by LW, both with `data_ok` in the same cycle. Expect: two consecutive requests, no bubble, `mem_busy` never asserted.
- Test 6: `reset` asserted during `REQ`. Expect: `dreq.valid`=0 and `dataM.valid`=0 next cycle, state `IDLE`.
